mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LEN_REG, default 32, data word width.
REQ-002 Parameter LEN_ADDR, default 16, memory address width.
REQ-003 Parameter MEM_LAT, default 1, memory read latency in cycles, legal range 1..4.
REQ-004 Parameter MAX_WAIT, default 4, consecutive denied fetch cycles before fetch is forced to win.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 if_req  in  1  fetch requests a read.
REQ-008 if_addr  in  LEN_ADDR  fetch read address.
REQ-009 if_gnt  out  1  fetch request accepted this cycle.
REQ-010 if_rvalid  out  1  fetch read data valid.
REQ-011 ex_req  in  1  execute requests an access.
REQ-012 ex_we  in  1  execute access is a store.
REQ-013 ex_addr  in  LEN_ADDR  execute address.
REQ-014 ex_wdata  in  LEN_REG  execute store data.
REQ-015 ex_gnt  out  1  execute request accepted this cycle.
REQ-016 ex_rvalid  out  1  execute load data valid.
REQ-017 rdata  out  LEN_REG  read data, shared by both requesters, qualified by if_rvalid/ex_rvalid.
REQ-018 mem_en, mem_we  out  1 each  memory port enable and write strobe.
REQ-019 mem_addr  out  LEN_ADDR; mem_wdata  out  LEN_REG  memory port address and data.
REQ-020 mem_rdata  in  LEN_REG  memory data, valid MEM_LAT cycles after a read enable.

Function
REQ-021 FSM states: IDLE, RD_IF, RD_EX; at most one read outstanding.
REQ-022 Grant decision is combinational; it is allowed in IDLE, or in RD_* on the cycle the outstanding read completes (back-to-back).
REQ-023 Priority: ex wins over if, except when starve_cnt == MAX_WAIT, in which case if wins.
REQ-024 On a grant, mem_en=1 with the winner's address/we/wdata in the same cycle; exactly one of if_gnt/ex_gnt is 1.
REQ-025 Store grant (ex_we=1): single cycle, no response, FSM remains or returns to IDLE.
REQ-026 Read grant: FSM enters RD_IF/RD_EX and lat_cnt loads MEM_LAT-1.
REQ-027 In RD_*, lat_cnt decrements each cycle; when it reaches 0, the matching rvalid is 1 for exactly one cycle with rdata = mem_rdata.
REQ-028 No grant is issued in RD_* before completion; mem_en=0 on those cycles.
REQ-029 starve_cnt increments (saturating at MAX_WAIT) each cycle if_req=1 and if_gnt=0; it clears on if_gnt or when if_req=0.
REQ-030 Both requesters hold req and payload stable until granted; the arbiter never drops a granted request.
REQ-031 if_rvalid and ex_rvalid are never 1 simultaneously.
REQ-032 When not granting, mem_we=0 and mem_addr/mem_wdata are don't-care.

Reset
REQ-033 While rst=1: state=IDLE, lat_cnt=0, starve_cnt=0, all gnt/rvalid/mem_en/mem_we=0, rdata=0.
REQ-034 Reset asserted mid-read abandons the read; no rvalid is issued after reset release for it.
REQ-035 First grant is possible on the first posedge clk after rst deasserts.

Structure
REQ-036 State encoding and the MEM_LAT range constant reside in the shared defs package alongside the instruction definitions.
REQ-037 No sub-module; a single FSM plus two counters.

Verification
REQ-038 MEM_LAT=1; if_req only, addr 0x0010, mem returns 0xDEADBEEF -> if_gnt in cycle 0, if_rvalid=1 with rdata 0xDEADBEEF in cycle 1.
REQ-039 if_req and ex_req (load, 0x0200) together in IDLE -> ex_gnt first, if_gnt on ex completion cycle, responses in that order.
REQ-040 MAX_WAIT=4; ex issues continuous stores, if_req held -> if_gnt exactly on the 5th cycle, starve_cnt then 0.
REQ-041 MEM_LAT=3; ex load granted at cycle 0 -> mem_en=0 cycles 1-2, ex_rvalid at cycle 3 only.
REQ-042 rst pulsed at cycle 1 of a MEM_LAT=3 fetch read -> all outputs 0 immediately; no if_rvalid afterwards.
REQ-043 ex store 0x1234_5678 to 0x0004 -> mem_en=1, mem_we=1 for one cycle, no rvalid.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter.
//   - FSM state encoding
//   - legal memory-latency range and the latency-counter width derived from it
//   - requester access kinds (load/store) with a decode helper
package mem_arbiter_pkg;

  // Arbiter states: idle, fetch read outstanding, execute read outstanding.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRdIf = 2'd1,
    StRdEx = 2'd2
  } arb_state_e;

  // Legal memory read latency range (cycles).
  localparam int unsigned MemLatMin = 1;
  localparam int unsigned MemLatMax = 4;

  // Latency counter only ever holds MEM_LAT-1, so it must reach MemLatMax-1.
  localparam int unsigned LatCntW = $clog2(MemLatMax);

  // Access kinds issued by the execute requester.
  typedef enum logic {
    AccLoad  = 1'b0,
    AccStore = 1'b1
  } acc_kind_e;

  function automatic acc_kind_e acc_kind(input logic we);
    return we ? AccStore : AccLoad;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (fetch and execute) in front of a single
// fixed-latency memory port.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   if_req/if_addr        fetch read request and address
//   if_gnt/if_rvalid      fetch request accepted / fetch read data valid
//   ex_req/ex_we/ex_addr  execute request, store flag, address
//   ex_wdata              execute store data
//   ex_gnt/ex_rvalid      execute request accepted / execute load data valid
//   rdata                 shared read data, qualified by if_rvalid/ex_rvalid
//   mem_en/mem_we         memory port enable and write strobe
//   mem_addr/mem_wdata    memory port address and write data
//   mem_rdata             memory read data, valid MEM_LAT cycles after a read
//
// Execute normally wins; fetch wins once it has been denied MAX_WAIT cycles
// in a row. At most one read is outstanding; a new grant may be issued on
// the cycle the outstanding read completes.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LEN_REG  = 32,
  parameter int unsigned LEN_ADDR = 16,
  parameter int unsigned MEM_LAT  = 1,  // legal range MemLatMin..MemLatMax
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [LEN_ADDR-1:0] if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  input  logic                ex_req,
  input  logic                ex_we,
  input  logic [LEN_ADDR-1:0] ex_addr,
  input  logic [LEN_REG-1:0]  ex_wdata,
  output logic                ex_gnt,
  output logic                ex_rvalid,
  output logic [LEN_REG-1:0]  rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [LEN_ADDR-1:0] mem_addr,
  output logic [LEN_REG-1:0]  mem_wdata,
  input  logic [LEN_REG-1:0]  mem_rdata
);

  // +2 keeps the width non-zero for MAX_WAIT=0 and wide enough to hold MAX_WAIT.
  localparam int unsigned StarveW = $clog2(MAX_WAIT + 2);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(MAX_WAIT);
  localparam logic [LatCntW-1:0] LatLoad = LatCntW'(MEM_LAT - 1);

  arb_state_e          r_state;
  logic [LatCntW-1:0]  r_lat_cnt;
  logic [StarveW-1:0]  r_starve_cnt;

  logic      w_rd_done;
  logic      w_can_grant;
  logic      w_starved;
  logic      w_if_wins;
  logic      w_ex_wins;
  acc_kind_e w_ex_kind;

  // Grant decision
  always_comb begin
    w_ex_kind   = acc_kind(ex_we);
    w_rd_done   = (r_state != StIdle) && (r_lat_cnt == '0);
    // Grants are masked during reset so outputs drop the moment rst rises.
    w_can_grant = !rst && ((r_state == StIdle) || w_rd_done);
    w_starved   = (r_starve_cnt == StarveMax);
    w_if_wins   = w_can_grant && if_req && (!ex_req || w_starved);
    w_ex_wins   = w_can_grant && ex_req && !w_if_wins;
  end

  // Requester and memory-port outputs
  always_comb begin
    if_gnt    = w_if_wins;
    ex_gnt    = w_ex_wins;
    if_rvalid = !rst && (r_state == StRdIf) && (r_lat_cnt == '0);
    ex_rvalid = !rst && (r_state == StRdEx) && (r_lat_cnt == '0);
    rdata     = (if_rvalid || ex_rvalid) ? mem_rdata : '0;

    mem_en    = w_if_wins || w_ex_wins;
    mem_we    = w_ex_wins && (w_ex_kind == AccStore);
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_ex_wins) begin
      mem_addr = ex_addr;
      if (w_ex_kind == AccStore) begin
        mem_wdata = ex_wdata;
      end
    end else if (w_if_wins) begin
      mem_addr = if_addr;
    end
  end

  // FSM and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_if_wins) begin
        r_state   <= StRdIf;
        r_lat_cnt <= LatLoad;
      end else if (w_ex_wins && (w_ex_kind == AccLoad)) begin
        r_state   <= StRdEx;
        r_lat_cnt <= LatLoad;
      end else if (w_ex_wins || w_rd_done) begin
        // Store granted (no response) or read completed with no new read.
        r_state   <= StIdle;
        r_lat_cnt <= '0;
      end else if (r_state != StIdle) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end

      if (!if_req || w_if_wins) begin
        r_starve_cnt <= '0;
      end else if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 (u_dut) and one
// with MEM_LAT=3 (u_dut3) share all inputs; each scenario checks one of them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        ex_req;
  logic        ex_we;
  logic [15:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] mem_rdata;

  logic        a_if_gnt, a_if_rvalid, a_ex_gnt, a_ex_rvalid, a_mem_en, a_mem_we;
  logic [31:0] a_rdata, a_mem_wdata;
  logic [15:0] a_mem_addr;
  logic        b_if_gnt, b_if_rvalid, b_ex_gnt, b_ex_rvalid, b_mem_en, b_mem_we;
  logic [31:0] b_rdata, b_mem_wdata;
  logic [15:0] b_mem_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter u_dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (a_if_gnt),
    .if_rvalid (a_if_rvalid),
    .ex_req    (ex_req),
    .ex_we     (ex_we),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_gnt    (a_ex_gnt),
    .ex_rvalid (a_ex_rvalid),
    .rdata     (a_rdata),
    .mem_en    (a_mem_en),
    .mem_we    (a_mem_we),
    .mem_addr  (a_mem_addr),
    .mem_wdata (a_mem_wdata),
    .mem_rdata (mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (b_if_gnt),
    .if_rvalid (b_if_rvalid),
    .ex_req    (ex_req),
    .ex_we     (ex_we),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_gnt    (b_ex_gnt),
    .ex_rvalid (b_ex_rvalid),
    .rdata     (b_rdata),
    .mem_en    (b_mem_en),
    .mem_we    (b_mem_we),
    .mem_addr  (b_mem_addr),
    .mem_wdata (b_mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive idle inputs and pulse reset; returns just after reset release.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; ex_req = 1'b0; ex_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance to the next cycle's drive point.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; ex_req = 1'b1; ex_we = 1'b0;
    if_addr = 16'h0010; ex_addr = 16'h0200; ex_wdata = 32'h0; mem_rdata = 32'hDEADBEEF;

    // Reset state, with both requests asserted to show grants are masked.
    next_cyc(); next_cyc(); #1;
    chk("rst_if_gnt",    a_if_gnt,    0);
    chk("rst_ex_gnt",    a_ex_gnt,    0);
    chk("rst_if_rvalid", a_if_rvalid, 0);
    chk("rst_ex_rvalid", a_ex_rvalid, 0);
    chk("rst_mem_en",    a_mem_en,    0);
    chk("rst_mem_we",    a_mem_we,    0);
    chk("rst_rdata",     a_rdata,     0);

    // Fetch-only read, MEM_LAT=1; grant on the first edge after release.
    next_cyc();
    rst = 1'b0; ex_req = 1'b0; if_req = 1'b1; if_addr = 16'h0010; #1;
    chk("f_if_gnt",   a_if_gnt,   1);
    chk("f_ex_gnt",   a_ex_gnt,   0);
    chk("f_mem_en",   a_mem_en,   1);
    chk("f_mem_we",   a_mem_we,   0);
    chk("f_mem_addr", a_mem_addr, 32'h0010);
    chk("f_rv_c0",    a_if_rvalid, 0);
    next_cyc(); if_req = 1'b0; #1;
    chk("f_rv_c1",    a_if_rvalid, 1);
    chk("f_rdata_c1", a_rdata,     32'hDEADBEEF);
    chk("f_en_c1",    a_mem_en,    0);
    next_cyc(); #1;
    chk("f_rv_c2",    a_if_rvalid, 0);
    chk("f_rdata_c2", a_rdata,     0);

    // Simultaneous fetch and execute load: ex first, fetch back-to-back.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0010; ex_req = 1'b1; ex_we = 1'b0; ex_addr = 16'h0200; #1;
    chk("p_ex_gnt_c0",  a_ex_gnt,   1);
    chk("p_if_gnt_c0",  a_if_gnt,   0);
    chk("p_addr_c0",    a_mem_addr, 32'h0200);
    next_cyc(); ex_req = 1'b0; mem_rdata = 32'h11112222; #1;
    chk("p_ex_rv_c1",   a_ex_rvalid, 1);
    chk("p_rdata_c1",   a_rdata,     32'h11112222);
    chk("p_if_gnt_c1",  a_if_gnt,    1);
    chk("p_addr_c1",    a_mem_addr,  32'h0010);
    chk("p_if_rv_c1",   a_if_rvalid, 0);
    next_cyc(); if_req = 1'b0; mem_rdata = 32'h33334444; #1;
    chk("p_if_rv_c2",   a_if_rvalid, 1);
    chk("p_ex_rv_c2",   a_ex_rvalid, 0);
    chk("p_rdata_c2",   a_rdata,     32'h33334444);

    // Starvation: continuous ex stores, fetch held; fetch wins on 5th cycle.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0040;
    ex_req = 1'b1; ex_we = 1'b1; ex_addr = 16'h0008; ex_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("s_ex_gnt_c%0d", i), a_ex_gnt, 1);
      chk($sformatf("s_if_gnt_c%0d", i), a_if_gnt, 0);
      next_cyc();
    end
    #1;
    chk("s_if_gnt_c4", a_if_gnt,   1);
    chk("s_ex_gnt_c4", a_ex_gnt,   0);
    chk("s_we_c4",     a_mem_we,   0);
    chk("s_addr_c4",   a_mem_addr, 32'h0040);
    // Counter restarted from 0: ex wins four more cycles, fetch on the fifth.
    for (int i = 5; i < 9; i++) begin
      next_cyc(); #1;
      chk($sformatf("s_ex_gnt_c%0d", i), a_ex_gnt, 1);
      chk($sformatf("s_if_gnt_c%0d", i), a_if_gnt, 0);
    end
    next_cyc(); #1;
    chk("s_if_gnt_c9", a_if_gnt, 1);

    // Single execute store.
    do_reset();
    ex_req = 1'b1; ex_we = 1'b1; ex_addr = 16'h0004; ex_wdata = 32'h12345678; #1;
    chk("w_gnt",   a_ex_gnt,    1);
    chk("w_en",    a_mem_en,    1);
    chk("w_we",    a_mem_we,    1);
    chk("w_addr",  a_mem_addr,  32'h0004);
    chk("w_wdata", a_mem_wdata, 32'h12345678);
    next_cyc(); ex_req = 1'b0; ex_we = 1'b0; #1;
    chk("w_en_c1", a_mem_en,    0);
    chk("w_we_c1", a_mem_we,    0);
    chk("w_rv_c1", a_ex_rvalid, 0);
    next_cyc(); #1;
    chk("w_rv_c2", a_ex_rvalid, 0);

    // MEM_LAT=3 execute load; fetch waiting is not granted mid-read.
    do_reset();
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 16'h0300; #1;
    chk("l3_ex_gnt_c0", b_ex_gnt, 1);
    chk("l3_en_c0",     b_mem_en, 1);
    for (int i = 1; i < 3; i++) begin
      next_cyc(); ex_req = 1'b0; if_req = 1'b1; if_addr = 16'h0020; #1;
      chk($sformatf("l3_en_c%0d", i),    b_mem_en,    0);
      chk($sformatf("l3_ifg_c%0d", i),   b_if_gnt,    0);
      chk($sformatf("l3_exrv_c%0d", i),  b_ex_rvalid, 0);
    end
    next_cyc(); mem_rdata = 32'hCAFEF00D; #1;
    chk("l3_exrv_c3",  b_ex_rvalid, 1);
    chk("l3_rdata_c3", b_rdata,     32'hCAFEF00D);
    chk("l3_ifg_c3",   b_if_gnt,    1);
    chk("l3_ifrv_c3",  b_if_rvalid, 0);
    next_cyc(); if_req = 1'b0; #1;
    chk("l3_exrv_c4",  b_ex_rvalid, 0);
    chk("l3_en_c4",    b_mem_en,    0);

    // Reset mid-read abandons a MEM_LAT=3 fetch.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0010; #1;
    chk("r_if_gnt_c0", b_if_gnt, 1);
    next_cyc(); #1;
    chk("r_en_c1", b_mem_en, 0);
    rst = 1'b1; ex_req = 1'b1; #1;
    chk("r_if_gnt_rst", b_if_gnt,    0);
    chk("r_ex_gnt_rst", b_ex_gnt,    0);
    chk("r_en_rst",     b_mem_en,    0);
    chk("r_we_rst",     b_mem_we,    0);
    chk("r_ifrv_rst",   b_if_rvalid, 0);
    chk("r_rdata_rst",  b_rdata,     0);
    next_cyc(); rst = 1'b0; if_req = 1'b0; ex_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("r_ifrv_post%0d", i), b_if_rvalid, 0);
      next_cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
